// File: rtl/f2_seq_ctrl.sv
// rtl/f2_seq_ctrl.sv - f2 feature-map RAM sequencer: pool1 fill addressing, conv2 KxK window reads.
// Data bypasses this block; it only produces RAM addresses, enables and latency-aligned read flags.
module f2_seq_ctrl #(
   parameter int MAP_W  = 14,
   parameter int MAP_H  = 14,
   parameter int K      = 5,
   parameter int AW     = 10,
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pool_valid,
   input  logic          conv_start,
   output logic          f2_wr_en,
   output logic [AW-1:0] f2_waddr,
   output logic [AW-1:0] f2_raddr,
   output logic          rd_valid,
   output logic          rd_win_first,
   output logic          rd_win_last,
   output logic          map_ready,
   output logic          busy,
   output logic          done,
   output logic          ovf_err
);

   localparam int NPIX = MAP_W * MAP_H;
   localparam int OXN  = MAP_W - K + 1;
   localparam int OYN  = MAP_H - K + 1;
   localparam int WCW  = $clog2(NPIX + 1);
   localparam int KW   = (K > 1)   ? $clog2(K)   : 1;
   localparam int OXW  = (OXN > 1) ? $clog2(OXN) : 1;
   localparam int OYW  = (OYN > 1) ? $clog2(OYN) : 1;
   localparam int DW   = $clog2(RD_LAT + 1);

   if (NPIX > (1 << AW)) begin : g_aw_check
      $error("f2_seq_ctrl: MAP_W*MAP_H exceeds 2**AW");
   end

   typedef enum logic [2:0] {
      S_FILL,
      S_FULL,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          state;
   logic [WCW-1:0]  wcnt;
   logic [KW-1:0]   kx;
   logic [KW-1:0]   ky;
   logic [OXW-1:0]  ox;
   logic [OYW-1:0]  oy;
   logic [AW-1:0]   win_base;
   logic [AW-1:0]   row_base;
   logic [DW-1:0]   dcnt;
   logic [RD_LAT:0] pipe_v;
   logic [RD_LAT:0] pipe_f;
   logic [RD_LAT:0] pipe_l;
   logic            done_r;
   logic            ovf_r;

   logic issue;
   logic tap_first;
   logic tap_last;

   assign issue     = (state == S_READ);
   assign tap_first = (kx == '0) && (ky == '0);
   assign tap_last  = (kx == KW'(K - 1)) && (ky == KW'(K - 1));

   assign f2_wr_en     = pool_valid && (state == S_FILL);
   assign f2_waddr     = AW'(wcnt);
   assign map_ready    = (state == S_FULL);
   assign busy         = (state == S_READ) || (state == S_DRAIN);
   assign done         = done_r;
   assign ovf_err      = ovf_r;
   assign rd_valid     = pipe_v[RD_LAT];
   assign rd_win_first = pipe_f[RD_LAT];
   assign rd_win_last  = pipe_l[RD_LAT];

   // Stage 0 of the flag chain lines up with f2_raddr; stage RD_LAT lines up with RAM data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_FILL;
         wcnt     <= '0;
         kx       <= '0;
         ky       <= '0;
         ox       <= '0;
         oy       <= '0;
         win_base <= '0;
         row_base <= '0;
         dcnt     <= '0;
         pipe_v   <= '0;
         pipe_f   <= '0;
         pipe_l   <= '0;
         f2_raddr <= '0;
         done_r   <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         pipe_v <= {pipe_v[RD_LAT-1:0], issue};
         pipe_f <= {pipe_f[RD_LAT-1:0], issue && tap_first};
         pipe_l <= {pipe_l[RD_LAT-1:0], issue && tap_last};
         done_r <= 1'b0;
         if (pool_valid && (state != S_FILL)) begin
            ovf_r <= 1'b1;
         end
         case (state)
            S_FILL: begin
               if (pool_valid) begin
                  wcnt <= wcnt + WCW'(1);
                  if (wcnt == WCW'(NPIX - 1)) begin
                     state <= S_FULL;
                  end
               end
            end
            S_FULL: begin
               if (conv_start) begin
                  state    <= S_READ;
                  kx       <= '0;
                  ky       <= '0;
                  ox       <= '0;
                  oy       <= '0;
                  win_base <= '0;
                  row_base <= '0;
               end
            end
            S_READ: begin
               f2_raddr <= row_base + AW'(kx);
               // win_base tracks the window origin, row_base the current kernel row start.
               if (kx != KW'(K - 1)) begin
                  kx <= kx + KW'(1);
               end else begin
                  kx <= '0;
                  if (ky != KW'(K - 1)) begin
                     ky       <= ky + KW'(1);
                     row_base <= row_base + AW'(MAP_W);
                  end else begin
                     ky <= '0;
                     if (ox != OXW'(OXN - 1)) begin
                        ox       <= ox + OXW'(1);
                        win_base <= win_base + AW'(1);
                        row_base <= win_base + AW'(1);
                     end else begin
                        ox <= '0;
                        if (oy != OYW'(OYN - 1)) begin
                           // last window of a row to first of the next: +MAP_W-(MAP_W-K)
                           oy       <= oy + OYW'(1);
                           win_base <= win_base + AW'(K);
                           row_base <= win_base + AW'(K);
                        end else begin
                           state <= S_DRAIN;
                           dcnt  <= '0;
                        end
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (dcnt == DW'(RD_LAT - 1)) begin
                  state <= S_DONE;
                  dcnt  <= '0;
               end else begin
                  dcnt <= dcnt + DW'(1);
               end
            end
            S_DONE: begin
               done_r <= 1'b1;
               wcnt   <= '0;
               state  <= S_FILL;
            end
            default: state <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_f2_seq_ctrl.sv
// tb/tb_f2_seq_ctrl.sv - randomized bench for f2_seq_ctrl against a tap-index reference model.
module tb_f2_seq_ctrl;

   localparam int MW = 14, MH = 14, KK = 5, AWD = 10;
   localparam int NPIX = MW * MH;
   localparam int OXN = MW - KK + 1;
   localparam int TPW = KK * KK;
   localparam int TAPS = OXN * (MH - KK + 1) * TPW;

   logic clk = 1'b0;
   logic rst, pool_valid, conv_start;
   logic f2_wr_en, rd_valid, rd_win_first, rd_win_last, map_ready, busy, done, ovf_err;
   logic [AWD-1:0] f2_waddr, f2_raddr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   f2_seq_ctrl #(.MAP_W(MW), .MAP_H(MH), .K(KK), .AW(AWD), .RD_LAT(2)) dut (
      .clk(clk), .rst(rst), .pool_valid(pool_valid), .conv_start(conv_start),
      .f2_wr_en(f2_wr_en), .f2_waddr(f2_waddr), .f2_raddr(f2_raddr),
      .rd_valid(rd_valid), .rd_win_first(rd_win_first), .rd_win_last(rd_win_last),
      .map_ready(map_ready), .busy(busy), .done(done), .ovf_err(ovf_err)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Raster address of read tap number `tap` across the whole pass.
   function automatic int addr_of(input int tap);
      int w, t;
      w = tap / TPW;
      t = tap % TPW;
      return (w / OXN + t / KK) * MW + (w % OXN) + (t % KK);
   endfunction

   // Model phases: 0 fill, 1 map full, 2 issuing taps, 3 after last tap issued.
   int   m_ph, m_wr, m_tap, m_tail, m_raddr;
   bit   m_ovf, m_done, m_iss, m_fi, m_la;
   bit [2:0] dv, df, dl;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph = 0; m_wr = 0; m_tap = 0; m_tail = 0; m_raddr = 0;
         m_ovf = 0; m_done = 0; dv = 0; df = 0; dl = 0;
      end else begin
         m_iss = 0; m_fi = 0; m_la = 0;
         m_done = 0;
         if (pool_valid && m_ph != 0) m_ovf = 1;
         case (m_ph)
            0: if (pool_valid) begin
                  m_wr++;
                  if (m_wr == NPIX) m_ph = 1;
               end
            1: if (conv_start) begin
                  m_ph = 2;
                  m_tap = 0;
               end
            2: begin
                  m_raddr = addr_of(m_tap);
                  m_iss = 1;
                  m_fi = (m_tap % TPW == 0);
                  m_la = (m_tap % TPW == TPW - 1);
                  m_tap++;
                  if (m_tap == TAPS) begin
                     m_ph = 3;
                     m_tail = 0;
                  end
               end
            default: begin
                  m_tail++;
                  if (m_tail == 3) begin
                     m_done = 1;
                     m_ph = 0;
                     m_wr = 0;
                  end
               end
         endcase
         dv = {dv[1:0], m_iss};
         df = {df[1:0], m_fi};
         dl = {dl[1:0], m_la};
      end
   end

   always @(negedge clk) begin
      chk("f2_wr_en", f2_wr_en, int'(pool_valid && m_ph == 0));
      chk("f2_waddr", f2_waddr, m_wr);
      chk("f2_raddr", f2_raddr, m_raddr);
      chk("rd_valid", rd_valid, dv[2]);
      chk("rd_win_first", rd_win_first, df[2]);
      chk("rd_win_last", rd_win_last, dl[2]);
      chk("map_ready", map_ready, int'(m_ph == 1));
      chk("busy", busy, int'(m_ph == 2 || (m_ph == 3 && m_tail < 2)));
      chk("done", done, m_done);
      chk("ovf_err", ovf_err, m_ovf);
   end

   // Literal pass-level expectations: beat total and done latency after address 195.
   int cyc = 0, beats = 0, t195 = -1;
   int prev_raddr = 0;
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         beats = 0;
         t195 = -1;
      end else begin
         if (rd_valid) beats++;
         if (busy && f2_raddr == 195 && prev_raddr != 195) t195 = cyc;
         if (done) begin
            chk("done_latency_after_195", cyc - t195, 3);
            chk("rd_valid_beats", beats, 2500);
            beats = 0;
            t195 = -1;
         end
      end
      prev_raddr = int'(f2_raddr);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fill(input bit start_on_last, input bit start_noise);
      int n = 0;
      int guard = 0;
      while (n < NPIX && guard < 2000) begin
         pool_valid = ($urandom_range(0, 2) != 0);
         conv_start = start_noise && ($urandom_range(0, 7) == 0);
         if (pool_valid) begin
            n++;
            if (n == NPIX && start_on_last) conv_start = 1'b1;
         end
         step();
         guard++;
      end
      pool_valid = 1'b0;
      conv_start = 1'b0;
      chk("map_ready_after_fill", map_ready, 1);
      step();
      chk("start_with_last_write_ignored", busy, 0);
   endtask

   task automatic start_read();
      conv_start = 1'b1;
      step();
      conv_start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input bit noise);
      int c = 0;
      while (!done && c < 4000) begin
         if (noise) begin
            pool_valid = ($urandom_range(0, 9) == 0);
            conv_start = ($urandom_range(0, 9) == 0);
         end
         step();
         c++;
      end
      pool_valid = 1'b0;
      conv_start = 1'b0;
      chk("done_seen_in_time", int'(c < 4000), 1);
   endtask

   int base_lit[5] = '{0, 14, 28, 42, 56};
   int last_lit[5] = '{135, 149, 163, 177, 191};

   initial begin
      rst = 1'b1;
      pool_valid = 1'b0;
      conv_start = 1'b0;

      for (int i = 0; i < TPW; i++) begin
         chk("model_first_window", addr_of(i), base_lit[i / 5] + i % 5);
         chk("model_last_window", addr_of(TAPS - TPW + i), last_lit[i / 5] + i % 5);
      end
      chk("model_win1_base", addr_of(25), 1);
      chk("model_row1_base", addr_of(250), 14);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_wr_en", f2_wr_en, 0);
      chk("reset_waddr", f2_waddr, 0);
      chk("reset_raddr", f2_raddr, 0);
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_map_ready", map_ready, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_ovf", ovf_err, 0);
      rst = 1'b0;
      step();

      // Pass 1: start noise during fill, start with the last write, overflow during read.
      do_fill(1'b1, 1'b1);
      repeat (3) step();
      chk("ovf_clear_before_read", ovf_err, 0);
      start_read();
      wait_done(1'b1);
      chk("ovf_sticky_through_done", ovf_err, 1);
      repeat (2) step();

      // Pass 2: abort with reset at tap 1000.
      do_fill(1'b0, 1'b0);
      start_read();
      begin
         int c = 0;
         while (m_tap < 1000 && c < 3000) begin
            step();
            c++;
         end
         chk("reached_tap_1000", m_tap, 1000);
      end
      rst = 1'b1;
      #1;
      chk("abort_raddr", f2_raddr, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ovf", ovf_err, 0);
      chk("abort_done", done, 0);
      step();
      step();
      rst = 1'b0;
      step();

      // Pass 3: fresh fill/read after the abort.
      do_fill(1'b0, 1'b1);
      start_read();
      wait_done(1'b0);
      chk("ovf_clear_after_reset", ovf_err, 0);
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
